spike_synapse_driver: RTL and testbench

- Spike-to-current converter: the receive end of a neuron's spike output. Turns a 1-bit spike train into the 16-bit current_in that drives the next neuron model.
- Each accepted spike adds a weight to a synaptic current register. The register then decays exponentially, using shift-and-subtract on a prescaled tick.
- Enforces a refractory window. Counts accepted spikes and flags dropped ones.
- Sits between the spike output of one neuron and the current input of the next in a neuron chain.

---
 rtl/syn_pkg.sv | 58 +++++
 rtl/syn_decay_prescaler.sv | 47 ++++
 rtl/spike_synapse_driver.sv | 166 ++++++++++++++++
 tb/tb_spike_synapse_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
// Shared types and arithmetic helpers for the spike-to-current synapse driver.
// Latency: none (types, parameters and pure combinational functions only).
// Backpressure: none; nothing in here holds state.
//
// Contents:
//   syn_state_t     - IDLE (current is zero, prescaler parked) / ACTIVE (decaying)
//   SYN_WIDTH       - default current register width
//   SYN_WEIGHT_W    - default weight width
//   SYN_MAX_W       - width the helpers operate at; callers zero-extend into it
//   syn_sat_add     - unsigned add that clamps at 2^width-1 instead of wrapping
//   syn_decay_step  - current >> shift, raised to 1 so a nonzero current always drains
package syn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } syn_state_t;

  localparam int SYN_WIDTH    = 16;
  localparam int SYN_WEIGHT_W = 8;
  localparam int SYN_MAX_W    = 32;

  // Both operands must already be below 2^width. The sum is formed one bit
  // wider than the operands so a carry out can never wrap.
  function automatic logic [SYN_MAX_W-1:0] syn_sat_add(
    input logic [SYN_MAX_W-1:0] a,
    input logic [SYN_MAX_W-1:0] b,
    input int                   width
  );
    logic [SYN_MAX_W:0]   sum;
    logic [SYN_MAX_W-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    if (width >= SYN_MAX_W) begin
      lim = '1;
    end else begin
      lim = (SYN_MAX_W'(1) << width) - SYN_MAX_W'(1);
    end
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[SYN_MAX_W-1:0];
  endfunction

  // Without the minimum step, small currents would stall at a value below
  // 2^shift and never return to zero.
  function automatic logic [SYN_MAX_W-1:0] syn_decay_step(
    input logic [SYN_MAX_W-1:0] cur,
    input int                   shift
  );
    logic [SYN_MAX_W-1:0] d;
    d = cur >> shift;
    if (d == '0 && cur != '0) begin
      d = SYN_MAX_W'(1);
    end
    return d;
  endfunction

endpackage

// File: rtl/syn_decay_prescaler.sv
// Decay prescaler: free-running 0..PERIOD-1 counter that flags the decay tick.
// Latency: tick is combinational from the registered count (same cycle).
// Backpressure: hold freezes the count; clear parks it at zero.
//
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   hold         - keep the count unchanged (block disabled)
//   clear        - force the count to 0 (nothing to decay); wins over hold
//   tick         - high in the cycle the count sits at PERIOD-1 and is advancing
module syn_decay_prescaler
  import syn_pkg::*;
#(
  parameter int PERIOD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count_q;
  logic             at_last;

  assign at_last = (count_q == CNT_W'(PERIOD - 1));

  // Gating with clear matters when PERIOD == 1: the parked count would
  // otherwise already look like the last step.
  assign tick = at_last & ~hold & ~clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (!hold) begin
      if (at_last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spike_synapse_driver.sv
// Spike-to-current synapse: rising spike edges add a weight to a current register
// that decays by shift-and-subtract. Latency: current_out shows an add 1 cycle
// after spike_in is first sampled high. Backpressure: none; enable=0 freezes the block.
//
// Ports:
//   clock, reset - system clock, synchronous active-high reset (wins over everything)
//   enable       - low freezes accepts, decay and prescaler; spike_in is still tracked
//   spike_in     - level spike from the upstream neuron, rising edge is the event
//   weight       - synaptic weight, zero-extended, sampled on the accepting edge
//   current_out  - registered synaptic current, saturates at 2^WIDTH-1
//   active       - registered (current_out != 0)
//   dropped      - one-cycle pulse for an edge rejected inside the refractory window
//   spike_count  - accepted-spike counter, wraps at 2^16
//
// Build option: define SYN_SPIKE_COUNT_EN to build the spike counter; when it is
// left undefined spike_count is tied to 0 and nothing else changes.
module spike_synapse_driver
  import syn_pkg::*;
#(
  parameter int WIDTH        = SYN_WIDTH,
  parameter int WEIGHT_W     = SYN_WEIGHT_W,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4,
  parameter int REFRACT      = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                spike_in,
  input  logic [WEIGHT_W-1:0] weight,
  output logic [WIDTH-1:0]    current_out,
  output logic                active,
  output logic                dropped,
  output logic [15:0]         spike_count
);

  localparam int REFR_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  syn_state_t          state_q;
  syn_state_t          state_d;
  logic                spike_prev;
  logic                spike_edge;
  logic                accept;
  logic                reject;
  logic                tick;
  logic [REFR_W-1:0]   refr_cnt;
  logic [WIDTH-1:0]    current_q;
  logic [WIDTH-1:0]    current_d;
  logic                active_q;
  logic                dropped_q;
  logic [SYN_MAX_W-1:0] cur_ext;
  logic [SYN_MAX_W-1:0] weight_ext;
  logic [SYN_MAX_W-1:0] decayed_ext;
  logic [SYN_MAX_W-1:0] next_ext;

  // spike_prev clears on reset, so a spike held high through reset release
  // is seen as a fresh edge on the first cycle out of reset.
  assign spike_edge = spike_in & ~spike_prev;
  assign accept     = spike_edge & enable & (refr_cnt == '0);
  assign reject     = spike_edge & enable & (refr_cnt != '0);

  // The prescaler only runs while there is current to decay; in IDLE it is
  // parked at zero so the first tick after an accept is a full period away.
  syn_decay_prescaler #(
    .PERIOD (DECAY_PERIOD)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .hold  (~enable),
    .clear (enable & (state_q == IDLE)),
    .tick  (tick)
  );

  assign cur_ext    = SYN_MAX_W'(current_q);
  assign weight_ext = SYN_MAX_W'(weight);

  // Decay is applied before the add when a tick and an accept coincide.
  always_comb begin
    decayed_ext = cur_ext;
    if (tick) begin
      decayed_ext = cur_ext - syn_decay_step(cur_ext, DECAY_SHIFT);
    end
    next_ext = decayed_ext;
    if (accept) begin
      next_ext = syn_sat_add(decayed_ext, weight_ext, WIDTH);
    end
    current_d = next_ext[WIDTH-1:0];
  end

  if (WIDTH < SYN_MAX_W) begin : g_hi_bits
    // Upper bits of the helper result are always zero for this WIDTH.
    logic unused_hi;
    assign unused_hi = ^next_ext[SYN_MAX_W-1:WIDTH];
  end

  // The enable term keeps a zero-current ACTIVE state (weight 0 accept)
  // from falling back to IDLE while the block is frozen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (enable && !accept && current_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spike_prev <= 1'b0;
      current_q  <= '0;
      active_q   <= 1'b0;
      dropped_q  <= 1'b0;
      refr_cnt   <= '0;
    end else begin
      spike_prev <= spike_in;
      current_q  <= current_d;
      active_q   <= (current_d != '0);
      dropped_q  <= reject;
      // A rejected edge does not restart the window.
      if (enable) begin
        if (accept) begin
          refr_cnt <= REFR_W'(REFRACT);
        end else if (refr_cnt != '0) begin
          refr_cnt <= refr_cnt - REFR_W'(1);
        end
      end
    end
  end

  assign current_out = current_q;
  assign active      = active_q;
  assign dropped     = dropped_q;

`ifdef SYN_SPIKE_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign spike_count = count_q;
`else
  assign spike_count = '0;
`endif

endmodule

// File: tb/tb_spike_synapse_driver.sv
// Bench for spike_synapse_driver: directed scenarios plus a random phase, with a
// scoreboard fed by a high-level reference model and popped by a separate monitor.
// The weight port is widened to 16 bits so saturation is reachable with default decay.
module tb_spike_synapse_driver;

  localparam int TB_WIDTH  = 16;
  localparam int TB_WW     = 16;
  localparam int TB_SHIFT  = 3;
  localparam int TB_PERIOD = 4;
  localparam int TB_REFR   = 2;
  localparam int MAXV      = 65535;

  logic                clock;
  logic                reset;
  logic                enable;
  logic                spike_in;
  logic [TB_WW-1:0]    weight;
  logic [TB_WIDTH-1:0] current_out;
  logic                active;
  logic                dropped;
  logic [15:0]         spike_count;

  spike_synapse_driver #(
    .WIDTH        (TB_WIDTH),
    .WEIGHT_W     (TB_WW),
    .DECAY_SHIFT  (TB_SHIFT),
    .DECAY_PERIOD (TB_PERIOD),
    .REFRACT      (TB_REFR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .spike_in    (spike_in),
    .weight      (weight),
    .current_out (current_out),
    .active      (active),
    .dropped     (dropped),
    .spike_count (spike_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cur;
    int act;
    int drp;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: the synapse described as plain numbers.
  int m_cur, m_prev, m_refr, m_cnt, m_pre, m_busy;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic model_step(input bit r, input bit en, input bit spk, input int w,
                            output exp_t e);
    int edge_seen, tick, acc, drop, nc, d;
    drop = 0;
    if (r) begin
      m_cur = 0; m_prev = 0; m_refr = 0; m_cnt = 0; m_pre = 0; m_busy = 0;
    end else begin
      edge_seen = (spk && m_prev == 0) ? 1 : 0;
      m_prev = spk;
      if (en) begin
        tick = (m_busy != 0 && m_pre == TB_PERIOD - 1) ? 1 : 0;
        acc  = (edge_seen != 0 && m_refr == 0) ? 1 : 0;
        drop = (edge_seen != 0 && m_refr != 0) ? 1 : 0;
        nc = m_cur;
        if (tick != 0) begin
          d = m_cur / (1 << TB_SHIFT);
          if (d == 0 && m_cur != 0) d = 1;
          nc = nc - d;
        end
        if (acc != 0) begin
          nc = nc + w;
          if (nc > MAXV) nc = MAXV;
          m_refr = TB_REFR;
          m_cnt  = (m_cnt + 1) % 65536;
        end else if (m_refr > 0) begin
          m_refr = m_refr - 1;
        end
        m_pre = (m_busy != 0) ? (m_pre + 1) % TB_PERIOD : 0;
        if (acc != 0) m_busy = 1;
        else if (nc == 0) m_busy = 0;
        m_cur = nc;
      end
    end
    e.cur = m_cur;
    e.act = (m_cur != 0) ? 1 : 0;
    e.drp = drop;
`ifdef SYN_SPIKE_COUNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input bit r, input bit en, input bit spk, input int w);
    exp_t e;
    @(negedge clock);
    reset    = r;
    enable   = en;
    spike_in = spk;
    weight   = w[TB_WW-1:0];
    model_step(r, en, spk, w, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a fresh output, compare it to the
  // oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_current", int'(current_out), e.cur);
        check("sb_active", int'(active), e.act);
        check("sb_dropped", int'(dropped), e.drp);
        check("sb_count", int'(spike_count), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int w;
    reset    = 1'b1;
    enable   = 1'b1;
    spike_in = 1'b0;
    weight   = '0;

    // Reset state
    repeat (3) drive(1'b1, 1'b1, 1'b0, 0);
    settle();
    check("reset_current", int'(current_out), 0);
    check("reset_active", int'(active), 0);
    check("reset_count", int'(spike_count), 0);

    // Single spike and decay: 100, 88, 77, 68, ... down to 0
    drive(1'b0, 1'b1, 1'b1, 100);
    settle();
    check("single_add", int'(current_out), 100);
    check("single_active", int'(active), 1);
    idle(4); settle(); check("decay_88", int'(current_out), 88);
    idle(4); settle(); check("decay_77", int'(current_out), 77);
    idle(4); settle(); check("decay_68", int'(current_out), 68);
    idle(140); settle();
    check("decay_zero", int'(current_out), 0);
    check("decay_inactive", int'(active), 0);

    // Refractory: edge k accepted, k+2 dropped, k+4 accepted (100-12+100)
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 100);
    drive(1'b0, 1'b1, 1'b0, 100);
    drive(1'b0, 1'b1, 1'b1, 100);
    settle(); check("refr_dropped", int'(dropped), 1);
    drive(1'b0, 1'b1, 1'b0, 100);
    settle(); check("refr_drop_pulse", int'(dropped), 0);
    drive(1'b0, 1'b1, 1'b1, 100);
    settle(); check("refr_reaccept", int'(current_out), 188);

    // Tick and accept in the same cycle: 80 - 10 + 10
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 80);
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 10);
    settle(); check("tick_accept", int'(current_out), 80);

    // Tail: 7 decays by the minimum step of 1
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 7);
    idle(4);
    settle(); check("tail_7_to_6", int'(current_out), 6);

    // Saturation
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 65500);
    idle(2);
    drive(1'b0, 1'b1, 1'b1, 200);
    settle(); check("sat_clamp", int'(current_out), 65535);
    idle(2);
    settle(); check("sat_decay", int'(current_out), 57344);
    drive(1'b0, 1'b1, 1'b1, 65535);
    settle(); check("sat_again", int'(current_out), 65535);

    // Enable low for 10 cycles with edges: everything frozen
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 100);
    drive(1'b0, 1'b1, 1'b0, 100);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, (i % 2) == 0, 100);
    settle(); check("freeze_current", int'(current_out), 100);
    check("freeze_dropped", int'(dropped), 0);
    idle(2); settle(); check("resume_hold", int'(current_out), 100);
    idle(1); settle(); check("resume_tick", int'(current_out), 88);

    // Reset mid-decay with spike_in held high through release
    idle(3);
    drive(1'b1, 1'b1, 1'b1, 100);
    drive(1'b1, 1'b1, 1'b1, 100);
    settle();
    check("midreset_current", int'(current_out), 0);
    check("midreset_active", int'(active), 0);
    drive(1'b0, 1'b1, 1'b1, 100);
    settle(); check("release_accept", int'(current_out), 100);

    // Random phase
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(3) == 0) w = int'($urandom_range(65535));
      else w = int'($urandom_range(255));
      drive($urandom_range(299) == 0, $urandom_range(9) != 0,
            $urandom_range(1) == 1, w);
    end

    // Drain the scoreboard
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    #2;
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
